cdiv_sched: RTL and testbench

//  Round-robin scheduler that shares one pipelined complex divider (a/b -> p) among NUM_REQ

---
 rtl/cdiv_sched_pkg.sv | 32 +++
 rtl/cdiv_tag_fifo.sv | 49 ++++
 rtl/cdiv_sched.sv | 133 +++++++++++++
 tb/tb_cdiv_sched.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdiv_sched_pkg.sv
// Shared widths, operand types and lane helpers for the complex-divider scheduler.
package cdiv_sched_pkg;

    localparam int unsigned CDIV_OPER_W  = 16;
    localparam int unsigned CDIV_QUOT_W  = 32;
    localparam int unsigned CDIV_MAX_REQ = 8;
    localparam int unsigned CDIV_LANE_W  = CDIV_MAX_REQ * CDIV_OPER_W;
    localparam int unsigned CDIV_IDX_W   = $clog2(CDIV_MAX_REQ);

    typedef logic [CDIV_OPER_W-1:0] cdiv_oper_t;
    typedef logic [CDIV_LANE_W-1:0] cdiv_lanes_t;

    typedef struct packed {
        cdiv_oper_t re;
        cdiv_oper_t im;
    } cdiv_cplx_t;

    function automatic cdiv_oper_t cdiv_get_lane(input cdiv_lanes_t lanes,
                                                 input logic [CDIV_IDX_W-1:0] idx);
        return lanes[idx*CDIV_OPER_W +: CDIV_OPER_W];
    endfunction

    function automatic cdiv_lanes_t cdiv_set_lane(input cdiv_lanes_t lanes,
                                                  input logic [CDIV_IDX_W-1:0] idx,
                                                  input cdiv_oper_t val);
        cdiv_lanes_t res;
        res = lanes;
        res[idx*CDIV_OPER_W +: CDIV_OPER_W] = val;
        return res;
    endfunction

endpackage

// File: rtl/cdiv_tag_fifo.sv
// Show-ahead synchronous FIFO holding the requester tag of each in-flight division.
module cdiv_tag_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cdiv_sched.sv
// Round-robin sharing of one in-order pipelined complex divider among NUM_REQ requesters.
// Define CDIV_SCHED_PRIO_EN to give requester 0 strict priority over the round-robin group.
module cdiv_sched
    import cdiv_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned TAG_DEPTH = 64,
    parameter int unsigned TAG_W     = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*CDIV_OPER_W-1:0] req_a_i,
    input  logic [NUM_REQ*CDIV_OPER_W-1:0] req_a_q,
    input  logic [NUM_REQ*CDIV_OPER_W-1:0] req_b_i,
    input  logic [NUM_REQ*CDIV_OPER_W-1:0] req_b_q,
    output logic [CDIV_OPER_W-1:0]       div_a_i,
    output logic [CDIV_OPER_W-1:0]       div_a_q,
    output logic [CDIV_OPER_W-1:0]       div_b_i,
    output logic [CDIV_OPER_W-1:0]       div_b_q,
    output logic                         div_in_strobe,
    input  logic [CDIV_QUOT_W-1:0]       div_p_i,
    input  logic [CDIV_QUOT_W-1:0]       div_p_q,
    input  logic                         div_out_strobe,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [CDIV_QUOT_W-1:0]       rsp_p_i,
    output logic [CDIV_QUOT_W-1:0]       rsp_p_q,
    output logic [$clog2(TAG_DEPTH):0]   in_flight,
    output logic                         err_orphan
);

    logic [TAG_W-1:0]   ptr;
    logic [TAG_W-1:0]   grant_idx;
    logic [TAG_W-1:0]   cand;
    logic [TAG_W-1:0]   tag_head;
    logic [NUM_REQ-1:0] rr_valid;
    logic               grant_any;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    cdiv_cplx_t         div_a;
    cdiv_cplx_t         div_b;

    assign pop     = div_out_strobe && !fifo_empty;
    assign div_a_i = div_a.re;
    assign div_a_q = div_a.im;
    assign div_b_i = div_b.re;
    assign div_b_q = div_b.im;

    // Arbiter: first valid requester at or after ptr, from registered state only.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        req_ready = '0;
        rr_valid  = req_valid;
`ifdef CDIV_SCHED_PRIO_EN
        rr_valid[0] = 1'b0;
`endif
        if (enable && !fifo_full) begin
`ifdef CDIV_SCHED_PRIO_EN
            if (req_valid[0]) grant_any = 1'b1;
`endif
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cand = TAG_W'((32'(ptr) + i) % NUM_REQ);
                if (!grant_any && rr_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
            if (grant_any) req_ready = NUM_REQ'(1) << grant_idx;
        end
    end

    // Issue stage: latch granted operands, strobe the divider, advance the pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr           <= '0;
            div_a         <= '0;
            div_b         <= '0;
            div_in_strobe <= 1'b0;
        end else begin
            div_in_strobe <= grant_any;
            if (grant_any) begin
                div_a.re <= cdiv_get_lane(CDIV_LANE_W'(req_a_i), CDIV_IDX_W'(grant_idx));
                div_a.im <= cdiv_get_lane(CDIV_LANE_W'(req_a_q), CDIV_IDX_W'(grant_idx));
                div_b.re <= cdiv_get_lane(CDIV_LANE_W'(req_b_i), CDIV_IDX_W'(grant_idx));
                div_b.im <= cdiv_get_lane(CDIV_LANE_W'(req_b_q), CDIV_IDX_W'(grant_idx));
`ifdef CDIV_SCHED_PRIO_EN
                if (grant_idx != '0) ptr <= TAG_W'((32'(grant_idx) + 1) % NUM_REQ);
`else
                ptr <= TAG_W'((32'(grant_idx) + 1) % NUM_REQ);
`endif
            end
        end
    end

    // Return stage: route each quotient to the requester at the FIFO head.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid  <= '0;
            rsp_p_i    <= '0;
            rsp_p_q    <= '0;
            err_orphan <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (pop) begin
                rsp_valid <= NUM_REQ'(1) << tag_head;
                rsp_p_i   <= div_p_i;
                rsp_p_q   <= div_p_q;
            end
            if (div_out_strobe && fifo_empty) err_orphan <= 1'b1;
        end
    end

    cdiv_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (grant_any),
        .push_data (grant_idx),
        .pop       (pop),
        .pop_data  (tag_head),
        .count     (in_flight),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_cdiv_sched.sv
// Bench for cdiv_sched: two instances (tag depth 64 and 8) sharing stimulus, each with
// a 40-stage divider model and a response scoreboard.
module tb_cdiv_sched;

    localparam int NR  = 4;
    localparam int LAT = 40;

    typedef struct packed {
        logic [3:0]  v;
        logic [31:0] pi;
        logic [31:0] pq;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        pipe_clr;
    logic [3:0]  req_valid;
    logic [63:0] req_a_i, req_a_q, req_b_i, req_b_q;

    logic [3:0]  a_ready, b_ready;
    logic [15:0] a_div_a_i, a_div_a_q, a_div_b_i, a_div_b_q;
    logic [15:0] b_div_a_i, b_div_a_q, b_div_b_i, b_div_b_q;
    logic        a_div_in_strobe, b_div_in_strobe;
    logic [31:0] a_div_p_i, a_div_p_q, b_div_p_i, b_div_p_q;
    logic        a_div_out_strobe, b_div_out_strobe;
    logic [3:0]  a_rsp_valid, b_rsp_valid;
    logic [31:0] a_rsp_p_i, a_rsp_p_q, b_rsp_p_i, b_rsp_p_q;
    logic [6:0]  a_in_flight;
    logic [3:0]  b_in_flight;
    logic        a_err_orphan, b_err_orphan;

    logic        a_pv [LAT];
    logic [31:0] a_ppi [LAT], a_ppq [LAT];
    logic        b_pv [LAT];
    logic [31:0] b_ppi [LAT], b_ppq [LAT];

    exp_t a_exp[$], b_exp[$];
    int   errors = 0, checks = 0;
    int   a_rsp_cnt = 0, b_rsp_cnt = 0, a_ostb = 0;
    int   a_gcnt [NR], b_gcnt [NR];
    int   m_ptr = 0;
    int   seq = 1;

    always #5 clock = ~clock;

    cdiv_sched dut (
        .clock(clock), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_ready(a_ready),
        .req_a_i(req_a_i), .req_a_q(req_a_q), .req_b_i(req_b_i), .req_b_q(req_b_q),
        .div_a_i(a_div_a_i), .div_a_q(a_div_a_q), .div_b_i(a_div_b_i), .div_b_q(a_div_b_q),
        .div_in_strobe(a_div_in_strobe), .div_p_i(a_div_p_i), .div_p_q(a_div_p_q),
        .div_out_strobe(a_div_out_strobe), .rsp_valid(a_rsp_valid),
        .rsp_p_i(a_rsp_p_i), .rsp_p_q(a_rsp_p_q), .in_flight(a_in_flight),
        .err_orphan(a_err_orphan)
    );

    cdiv_sched #(.TAG_DEPTH(8)) dut8 (
        .clock(clock), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_ready(b_ready),
        .req_a_i(req_a_i), .req_a_q(req_a_q), .req_b_i(req_b_i), .req_b_q(req_b_q),
        .div_a_i(b_div_a_i), .div_a_q(b_div_a_q), .div_b_i(b_div_b_i), .div_b_q(b_div_b_q),
        .div_in_strobe(b_div_in_strobe), .div_p_i(b_div_p_i), .div_p_q(b_div_p_q),
        .div_out_strobe(b_div_out_strobe), .rsp_valid(b_rsp_valid),
        .rsp_p_i(b_rsp_p_i), .rsp_p_q(b_rsp_p_q), .in_flight(b_in_flight),
        .err_orphan(b_err_orphan)
    );

    // Divider model: fixed 40-stage in-order pipe, quotient re = a_i*16 + a_q[3:0].
    always @(posedge clock) begin
        if (pipe_clr) begin
            for (int i = 0; i < LAT; i++) begin
                a_pv[i] <= 1'b0; a_ppi[i] <= '0; a_ppq[i] <= '0;
                b_pv[i] <= 1'b0; b_ppi[i] <= '0; b_ppq[i] <= '0;
            end
        end else begin
            a_pv[0]  <= a_div_in_strobe;
            a_ppi[0] <= 32'(a_div_a_i) * 32'd16 + 32'(a_div_a_q[3:0]);
            a_ppq[0] <= {a_div_b_i, a_div_b_q};
            b_pv[0]  <= b_div_in_strobe;
            b_ppi[0] <= 32'(b_div_a_i) * 32'd16 + 32'(b_div_a_q[3:0]);
            b_ppq[0] <= {b_div_b_i, b_div_b_q};
            for (int i = 1; i < LAT; i++) begin
                a_pv[i] <= a_pv[i-1]; a_ppi[i] <= a_ppi[i-1]; a_ppq[i] <= a_ppq[i-1];
                b_pv[i] <= b_pv[i-1]; b_ppi[i] <= b_ppi[i-1]; b_ppq[i] <= b_ppq[i-1];
            end
        end
    end

    assign a_div_out_strobe = a_pv[LAT-1];
    assign a_div_p_i        = a_ppi[LAT-1];
    assign a_div_p_q        = a_ppq[LAT-1];
    assign b_div_out_strobe = b_pv[LAT-1];
    assign b_div_p_i        = b_ppi[LAT-1];
    assign b_div_p_q        = b_ppq[LAT-1];

    // Scoreboard: every response must match the oldest outstanding grant.
    always @(negedge clock) begin
        exp_t e;
        if (a_div_out_strobe) a_ostb++;
        if (a_rsp_valid !== 4'b0000) begin
            checks++;
            a_rsp_cnt++;
            if (a_exp.size() == 0) begin
                errors++;
                $display("FAIL a_rsp_unexpected: rsp_valid=%b with nothing outstanding", a_rsp_valid);
            end else begin
                e = a_exp.pop_front();
                if ({a_rsp_valid, a_rsp_p_i, a_rsp_p_q} !== e) begin
                    errors++;
                    $display("FAIL a_rsp_data: got v=%b p=%h/%h, expected v=%b p=%h/%h",
                             a_rsp_valid, a_rsp_p_i, a_rsp_p_q, e.v, e.pi, e.pq);
                end
            end
        end
        if (b_rsp_valid !== 4'b0000) begin
            checks++;
            b_rsp_cnt++;
            if (b_exp.size() == 0) begin
                errors++;
                $display("FAIL b_rsp_unexpected: rsp_valid=%b with nothing outstanding", b_rsp_valid);
            end else begin
                e = b_exp.pop_front();
                if ({b_rsp_valid, b_rsp_p_i, b_rsp_p_q} !== e) begin
                    errors++;
                    $display("FAIL b_rsp_data: got v=%b p=%h/%h, expected v=%b p=%h/%h",
                             b_rsp_valid, b_rsp_p_i, b_rsp_p_q, e.v, e.pi, e.pq);
                end
            end
        end
    end

    function automatic logic [3:0] exp_grant(input int p, input logic [3:0] v);
`ifdef CDIV_SCHED_PRIO_EN
        if (v[0]) return 4'b0001;
        v[0] = 1'b0;
`endif
        for (int i = 0; i < NR; i++) begin
            if (v[(p + i) % NR]) return 4'(1) << ((p + i) % NR);
        end
        return 4'b0000;
    endfunction

    function automatic int next_ptr(input int p, input logic [3:0] g);
        int k;
        k = -1;
        for (int i = 0; i < NR; i++) if (g[i]) k = i;
        if (k < 0) return p;
`ifdef CDIV_SCHED_PRIO_EN
        if (k == 0) return p;
`endif
        return (k + 1) % NR;
    endfunction

    function automatic exp_t expect_of(input int k);
        exp_t e;
        e.v  = 4'(1) << k;
        e.pi = 32'(req_a_i[16*k +: 16]) * 32'd16 + 32'(k);
        e.pq = {req_b_i[16*k +: 16], req_b_q[16*k +: 16]};
        return e;
    endfunction

    task automatic fresh_ops();
        for (int k = 0; k < NR; k++) begin
            req_a_i[16*k +: 16] = 16'(seq);
            req_a_q[16*k +: 16] = 16'(k);
            req_b_i[16*k +: 16] = 16'(seq) ^ 16'h5a5a;
            req_b_q[16*k +: 16] = 16'(k + 1);
            seq++;
        end
    endtask

    // Record the transfers that will happen at the coming edge.
    task automatic note_grants();
        if (!reset) begin
            for (int k = 0; k < NR; k++) begin
                if (req_valid[k] && a_ready[k]) begin a_exp.push_back(expect_of(k)); a_gcnt[k]++; end
                if (req_valid[k] && b_ready[k]) begin b_exp.push_back(expect_of(k)); b_gcnt[k]++; end
            end
        end
    endtask

    task automatic drain(output bit ok);
        int n;
        n = 0;
        @(negedge clock);
        req_valid = 4'b0000;
        while ((a_in_flight != 0 || b_in_flight != 0) && n < 200) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        ok = (a_in_flight == 0) && (b_in_flight == 0);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; pipe_clr = 1'b1; req_valid = 4'b0000;
        fresh_ops();
        repeat (3) @(negedge clock);
        #1;
        checks++; if (a_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b, expected 0000", a_ready); end
        checks++; if (a_div_in_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b, expected 0", a_div_in_strobe); end
        checks++; if ({a_div_a_i, a_div_a_q, a_div_b_i, a_div_b_q} !== 64'h0) begin errors++; $display("FAIL reset_operands: got %h, expected 0", {a_div_a_i, a_div_a_q, a_div_b_i, a_div_b_q}); end
        checks++; if ({a_rsp_valid, a_rsp_p_i, a_rsp_p_q} !== 68'h0) begin errors++; $display("FAIL reset_rsp: got %h, expected 0", {a_rsp_valid, a_rsp_p_i, a_rsp_p_q}); end
        checks++; if (a_in_flight !== 7'd0 || b_in_flight !== 4'd0) begin errors++; $display("FAIL reset_in_flight: got %0d/%0d, expected 0/0", a_in_flight, b_in_flight); end
        checks++; if (a_err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err_orphan: got %b, expected 0", a_err_orphan); end
        @(negedge clock);
        reset = 1'b0; pipe_clr = 1'b0; m_ptr = 0;
    endtask

    task automatic test_single();
        int cyc;
        @(negedge clock);
        req_a_i[15:0] = 16'd100; req_a_q[15:0] = 16'd0;
        req_b_i[15:0] = 16'd10;  req_b_q[15:0] = 16'd0;
        req_valid = 4'b0001; enable = 1'b1;
        #1;
        checks++; if (a_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b, expected 0001", a_ready); end
        note_grants();
        m_ptr = next_ptr(m_ptr, 4'b0001);
        @(negedge clock);
        req_valid = 4'b0000;
        #1;
        checks++; if (a_div_in_strobe !== 1'b1) begin errors++; $display("FAIL single_in_strobe: got %b, expected 1", a_div_in_strobe); end
        checks++; if ({a_div_a_i, a_div_a_q, a_div_b_i, a_div_b_q} !== {16'd100, 16'd0, 16'd10, 16'd0}) begin errors++; $display("FAIL single_operands: got %h, expected %h", {a_div_a_i, a_div_a_q, a_div_b_i, a_div_b_q}, {16'd100, 16'd0, 16'd10, 16'd0}); end
        checks++; if (a_in_flight !== 7'd1) begin errors++; $display("FAIL single_in_flight_1: got %0d, expected 1", a_in_flight); end
        cyc = 0;
        while (a_rsp_valid === 4'b0000 && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        #1;
        checks++; if (cyc != 41) begin errors++; $display("FAIL single_latency: got %0d cycles, expected 41", cyc); end
        checks++; if (a_in_flight !== 7'd0) begin errors++; $display("FAIL single_in_flight_0: got %0d, expected 0", a_in_flight); end
    endtask

    task automatic test_round_robin();
        logic [3:0] g;
        int cnt [NR];
        bit ok;
        for (int k = 0; k < NR; k++) cnt[k] = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            fresh_ops();
            req_valid = 4'b1111;
            #1;
            g = exp_grant(m_ptr, 4'b1111);
            checks++; if (a_ready !== g) begin errors++; $display("FAIL rr_grant c=%0d: got %b, expected %b", c, a_ready, g); end
            for (int k = 0; k < NR; k++) if (a_ready[k]) cnt[k]++;
            note_grants();
            m_ptr = next_ptr(m_ptr, g);
        end
`ifndef CDIV_SCHED_PRIO_EN
        for (int k = 0; k < NR; k++) begin
            checks++; if (cnt[k] != 4) begin errors++; $display("FAIL rr_count req%0d: got %0d, expected 4", k, cnt[k]); end
        end
`endif
        drain(ok);
        checks++; if (!ok || a_exp.size() != 0) begin errors++; $display("FAIL rr_drain: in_flight=%0d pending=%0d, expected 0/0", a_in_flight, a_exp.size()); end
    endtask

    task automatic test_depth_limit();
        int peak;
        int bg;
        logic [3:0] g;
        bit ok;
        peak = 0;
        for (int c = 0; c < 90; c++) begin
            @(negedge clock);
            fresh_ops();
            req_valid = 4'b1111;
            #1;
            if (int'(b_in_flight) > peak) peak = int'(b_in_flight);
            checks++;
            if (b_in_flight > 4'd8 || ((b_ready != 4'b0000) != (b_in_flight < 4'd8)) || !$onehot0(b_ready)) begin
                errors++; $display("FAIL depth_grant c=%0d: ready=%b in_flight=%0d, expected a single grant only below 8", c, b_ready, b_in_flight);
            end
            g = exp_grant(m_ptr, 4'b1111);
            checks++; if (a_ready !== g) begin errors++; $display("FAIL depth_a_grant c=%0d: got %b, expected %b", c, a_ready, g); end
            note_grants();
            m_ptr = next_ptr(m_ptr, g);
        end
        checks++; if (peak != 8) begin errors++; $display("FAIL depth_peak: got %0d, expected 8", peak); end
        drain(ok);
        bg = 0;
        for (int k = 0; k < NR; k++) bg += b_gcnt[k];
        checks++; if (!ok || b_exp.size() != 0 || bg != b_rsp_cnt) begin errors++; $display("FAIL depth_no_loss: grants=%0d responses=%0d pending=%0d, expected equal and 0 pending", bg, b_rsp_cnt, b_exp.size()); end
    endtask

    task automatic test_enable();
        logic [3:0] g;
        int rc0;
        bit ok;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            fresh_ops();
            req_valid = 4'b1111;
            #1;
            g = exp_grant(m_ptr, 4'b1111);
            checks++; if (a_ready !== g) begin errors++; $display("FAIL en_issue c=%0d: got %b, expected %b", c, a_ready, g); end
            note_grants();
            m_ptr = next_ptr(m_ptr, g);
        end
        @(negedge clock);
        req_valid = 4'b0000;
        repeat (32) @(negedge clock);
        rc0 = a_rsp_cnt;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            enable = 1'b0;
            fresh_ops();
            req_valid = 4'b1111;
            #1;
            checks++; if (a_ready !== 4'b0000 || a_div_in_strobe !== 1'b0) begin errors++; $display("FAIL en_frozen c=%0d: ready=%b strobe=%b, expected 0000/0", c, a_ready, a_div_in_strobe); end
            note_grants();
        end
        checks++; if (a_rsp_cnt - rc0 != 5) begin errors++; $display("FAIL en_returns: got %0d responses while disabled, expected 5", a_rsp_cnt - rc0); end
        @(negedge clock);
        enable = 1'b1;
        fresh_ops();
        #1;
        g = exp_grant(m_ptr, 4'b1111);
        checks++; if (a_ready !== g) begin errors++; $display("FAIL en_resume: got %b, expected %b", a_ready, g); end
        note_grants();
        m_ptr = next_ptr(m_ptr, g);
        drain(ok);
        checks++; if (!ok || a_exp.size() != 0) begin errors++; $display("FAIL en_drain: pending=%0d, expected 0", a_exp.size()); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] g;
        int ostb0;
        int rc0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            fresh_ops();
            req_valid = 4'b1111;
            #1;
            g = exp_grant(m_ptr, 4'b1111);
            note_grants();
            m_ptr = next_ptr(m_ptr, g);
        end
        @(negedge clock);
        req_valid = 4'b0000;
        #1;
        checks++; if (a_in_flight !== 7'd5) begin errors++; $display("FAIL rst_pre_in_flight: got %0d, expected 5", a_in_flight); end
        @(negedge clock);
        reset = 1'b1;
        a_exp.delete();
        b_exp.delete();
        ostb0 = a_ostb;
        rc0   = a_rsp_cnt;
        @(negedge clock);
        #1;
        checks++; if (a_in_flight !== 7'd0 || b_in_flight !== 4'd0) begin errors++; $display("FAIL rst_in_flight: got %0d/%0d, expected 0/0", a_in_flight, b_in_flight); end
        checks++; if ({a_ready, a_div_in_strobe, a_rsp_valid, a_err_orphan} !== 10'h0) begin errors++; $display("FAIL rst_ctrl: got %b, expected all 0", {a_ready, a_div_in_strobe, a_rsp_valid, a_err_orphan}); end
        checks++; if ({a_div_a_i, a_div_a_q, a_div_b_i, a_div_b_q, a_rsp_p_i, a_rsp_p_q} !== 128'h0) begin errors++; $display("FAIL rst_data: got %h, expected 0", {a_div_a_i, a_div_a_q, a_div_b_i, a_div_b_q, a_rsp_p_i, a_rsp_p_q}); end
        reset = 1'b0;
        m_ptr = 0;
        repeat (60) @(negedge clock);
        #1;
        checks++; if (a_ostb - ostb0 != 5) begin errors++; $display("FAIL rst_late_strobes: got %0d, expected 5", a_ostb - ostb0); end
        checks++; if (a_err_orphan !== 1'b1 || b_err_orphan !== 1'b1) begin errors++; $display("FAIL rst_err_orphan: got %b/%b, expected 1/1", a_err_orphan, b_err_orphan); end
        checks++; if (a_rsp_cnt != rc0) begin errors++; $display("FAIL rst_no_rsp: got %0d responses, expected 0", a_rsp_cnt - rc0); end
    endtask

`ifdef CDIV_SCHED_PRIO_EN
    task automatic test_prio();
        logic [3:0] g;
        logic [3:0] v;
        bit ok;
        for (int c = 0; c < 14; c++) begin
            v = (c < 6) ? 4'b1111 : 4'b1110;
            @(negedge clock);
            fresh_ops();
            req_valid = v;
            #1;
            g = exp_grant(m_ptr, v);
            checks++; if (a_ready !== g) begin errors++; $display("FAIL prio_grant c=%0d: got %b, expected %b", c, a_ready, g); end
            note_grants();
            m_ptr = next_ptr(m_ptr, g);
        end
        drain(ok);
        checks++; if (!ok || a_exp.size() != 0) begin errors++; $display("FAIL prio_drain: pending=%0d, expected 0", a_exp.size()); end
    endtask
`endif

    initial begin
        for (int k = 0; k < NR; k++) begin a_gcnt[k] = 0; b_gcnt[k] = 0; end
        test_reset();
        test_single();
        test_round_robin();
        test_depth_limit();
        test_enable();
        test_reset_mid();
`ifdef CDIV_SCHED_PRIO_EN
        test_prio();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
